mux2_rr_arbiter: RTL

- Shares one 2:1 data mux path between two requesters (A, B) using round-robin arbitration with a bounded hold.
- Drives the mux select and enable and registers the mux output into a single-entry output stage with a valid/ready handshake.
- Sits in front of the existing 2:1 mux datapath and replaces hand-driven select/enable stimulus with a sequenced controller.

---
 rtl/mux2_rr_arbiter.sv | 70 +++++++
 1 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin, hold-bounded arbiter driving a shared 2:1 mux into a registered valid/ready output stage
module mux2_rr_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic [DW-1:0] data_a,
  output logic          gnt_a,
  input  logic          req_b,
  input  logic [DW-1:0] data_b,
  output logic          gnt_b,
  output logic          se,
  output logic          en,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_A = 2'd1;
  localparam logic [1:0] GRANT_B = 2'd2;
  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic          last_b;
  logic          can_load, acc, own_req, oth_req, hold_hit, pick_a;
  // grants, accept strobe and owner-relative request views
  always_comb begin
    can_load = rst_n && (!out_valid || out_ready);
    gnt_a    = (state == GRANT_A) && can_load;
    gnt_b    = (state == GRANT_B) && can_load;
    acc      = (gnt_a && req_a) || (gnt_b && req_b);
    own_req  = (state == GRANT_B) ? req_b : req_a;
    oth_req  = (state == GRANT_B) ? req_a : req_b;
    hold_hit = acc && (hold_cnt == HW'(MAX_HOLD - 1));
    pick_a   = req_a && (!req_b || last_b);
  end
  // arbitration state, mux controls and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      se        <= 1'b0;
      en        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      hold_cnt  <= '0;
      last_b    <= 1'b1;
    end else begin
      if (acc) out_data <= se ? data_b : data_a;
      out_valid <= acc || (out_valid && !out_ready);
      if (state == IDLE) begin
        if (req_a || req_b) begin
          state    <= pick_a ? GRANT_A : GRANT_B;
          se       <= !pick_a;
          en       <= 1'b1;
          hold_cnt <= '0;
        end
      end else if (!own_req || (hold_hit && oth_req)) begin
        last_b   <= (state == GRANT_B);
        hold_cnt <= '0;
        state    <= oth_req ? ((state == GRANT_A) ? GRANT_B : GRANT_A) : IDLE;
        se       <= oth_req ? (state == GRANT_A) : se;
        en       <= oth_req;
      end else if (acc) begin
        hold_cnt <= hold_hit ? '0 : hold_cnt + 1'b1;
      end
    end
  end
endmodule
